// File: rtl/rd_budget_monitor_if.sv
// AXI read-address / read-data handshake bundle around rd_budget_monitor.
// Signal names mirror the monitor's ports so benches can wire them one-to-one.
interface rd_budget_monitor_if #(
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 8
);
  logic                 ar_valid_i;
  logic                 ar_ready_o;
  logic [IdWidth-1:0]   ar_id_i;
  logic [AddrWidth-1:0] ar_addr_i;
  logic [LenWidth-1:0]  ar_len_i;
  logic                 ar_valid_o;
  logic                 ar_ready_i;
  logic                 r_valid_i;
  logic                 r_ready_i;
  logic [IdWidth-1:0]   r_id_i;
  logic                 r_last_i;
  logic                 r_valid_o;
  logic                 r_ready_o;

  modport master (
    output ar_valid_i, ar_id_i, ar_addr_i,
    output ar_len_i, r_ready_i,
    input  ar_ready_o, r_valid_o
  );

  modport slave (
    output ar_ready_i, r_valid_i, r_id_i,
    output r_last_i,
    input  ar_valid_o, r_ready_o
  );

  modport mon (
    input  ar_valid_i, ar_id_i, ar_addr_i,
    input  ar_len_i, r_ready_i,
    input  ar_ready_i, r_valid_i, r_id_i,
    input  r_last_i,
    output ar_ready_o, r_valid_o,
    output ar_valid_o, r_ready_o
  );
endinterface

// File: rtl/rd_budget_monitor.sv
// AXI read watchdog: tracks outstanding reads against cycle budgets,
// checks R ordering/last, and can isolate a misbehaving slave.
module rd_budget_monitor #(
  parameter int NumTxns   = 4,
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 8,
  parameter int CntWidth  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         guard_ena_i,
  input  logic                         isolate_i,
  input  logic                         clear_i,
  input  logic                         ar_valid_i,
  output logic                         ar_ready_o,
  input  logic [IdWidth-1:0]           ar_id_i,
  input  logic [AddrWidth-1:0]         ar_addr_i,
  input  logic [LenWidth-1:0]          ar_len_i,
  output logic                         ar_valid_o,
  input  logic                         ar_ready_i,
  input  logic                         r_valid_i,
  input  logic                         r_ready_i,
  input  logic [IdWidth-1:0]           r_id_i,
  input  logic                         r_last_i,
  output logic                         r_valid_o,
  output logic                         r_ready_o,
  input  logic [CntWidth-1:0]          budget_first_i,
  input  logic [CntWidth-1:0]          budget_last_i,
  output logic                         fault_o,
  output logic                         irq_o,
  output logic [1:0]                   fault_code_o,
  output logic [AddrWidth-1:0]         fault_addr_o,
  output logic [CntWidth-1:0]          latency_o,
  output logic                         latency_valid_o,
  output logic [$clog2(NumTxns+1)-1:0] outstanding_o
);

  localparam int OutW = $clog2(NumTxns + 1);
  localparam int IdxW = (NumTxns > 1) ? $clog2(NumTxns) : 1;

  localparam logic [0:0] PhFirst = 1'b0;
  localparam logic [0:0] PhLast  = 1'b1;

  localparam logic [1:0] CodeFirst = 2'b01;
  localparam logic [1:0] CodeLast  = 2'b10;
  localparam logic [1:0] CodeProt  = 2'b11;

  logic [NumTxns-1:0]   busy_q;
  logic [IdWidth-1:0]   id_q    [NumTxns];
  logic [AddrWidth-1:0] addr_q  [NumTxns];
  logic [LenWidth-1:0]  len_q   [NumTxns];
  logic [LenWidth-1:0]  beats_q [NumTxns];
  logic [CntWidth-1:0]  cnt_q   [NumTxns];
  logic [0:0]           ph_q    [NumTxns];
  logic [OutW-1:0]      ord_q   [NumTxns];

  logic                 blk;
  logic                 acc;
  logic                 full;
  logic                 ar_hs;
  logic                 r_trk;
  logic                 hit;
  logic                 last_ok;
  logic                 retire;
  logic                 prot;
  logic                 to_hit;
  logic                 cap;
  logic [IdxW-1:0]      hit_idx;
  logic [IdxW-1:0]      free_idx;
  logic [IdxW-1:0]      to_idx;
  logic [1:0]           to_code;
  logic [1:0]           cap_code;
  logic [AddrWidth-1:0] cap_addr;
  logic [OutW-1:0]      n_busy;
  logic [OutW-1:0]      ord_new;

  assign full  = &busy_q;
  assign blk   = fault_o & isolate_i;
  assign acc   = guard_ena_i & ~full & ~blk;

  assign ar_valid_o = ar_valid_i & acc;
  assign ar_ready_o = ar_ready_i & acc;
  assign r_valid_o  = r_valid_i & ~blk;
  assign r_ready_o  = r_ready_i | blk;

  assign ar_hs = ar_valid_i & ar_ready_i & acc;
  assign r_trk = r_valid_i & r_ready_i
               & guard_ena_i & ~blk;

  assign outstanding_o = n_busy;

  always_comb begin
    n_busy = '0;
    for (int i = 0; i < NumTxns; i++) begin
      n_busy = n_busy + OutW'(busy_q[i]);
    end
  end

  // Lowest index wins: scan downward so the last write is the lowest.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NumTxns - 1; i >= 0; i--) begin
      if (busy_q[i] && id_q[i] == r_id_i
          && ord_q[i] == '0) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!busy_q[i]) begin
        free_idx = IdxW'(i);
      end
    end
  end

  assign last_ok = beats_q[hit_idx] == len_q[hit_idx];
  assign retire  = r_trk & hit & r_last_i & last_ok;
  assign prot    = r_trk
                 & (~hit | (r_last_i != last_ok));

  // Order of a new read counts same-id reads that survive this cycle.
  always_comb begin
    ord_new = '0;
    for (int j = 0; j < NumTxns; j++) begin
      ord_new = ord_new + OutW'(
        busy_q[j] && id_q[j] == ar_id_i
        && !(retire && hit_idx == IdxW'(j)));
    end
  end

  always_comb begin
    to_hit  = 1'b0;
    to_idx  = '0;
    to_code = CodeFirst;
    for (int i = NumTxns - 1; i >= 0; i--) begin
      if (guard_ena_i && busy_q[i]) begin
        if (ph_q[i] == PhFirst
            && cnt_q[i] >= budget_first_i) begin
          to_hit  = 1'b1;
          to_idx  = IdxW'(i);
          to_code = CodeFirst;
        end else if (ph_q[i] == PhLast
            && cnt_q[i] >= budget_last_i) begin
          to_hit  = 1'b1;
          to_idx  = IdxW'(i);
          to_code = CodeLast;
        end
      end
    end
  end

  assign cap = ~fault_o & ~clear_i & (prot | to_hit);

  always_comb begin
    cap_code = '0;
    cap_addr = '0;
    unique case (1'b1)
      prot: begin
        cap_code = CodeProt;
        cap_addr = hit ? addr_q[hit_idx] : '0;
      end
      (!prot && to_hit): begin
        cap_code = to_code;
        cap_addr = addr_q[to_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_o      <= 1'b0;
      irq_o        <= 1'b0;
      fault_code_o <= '0;
      fault_addr_o <= '0;
    end else if (clear_i) begin
      fault_o      <= 1'b0;
      irq_o        <= 1'b0;
      fault_code_o <= '0;
      fault_addr_o <= '0;
    end else begin
      irq_o <= cap;
      if (cap) begin
        fault_o      <= 1'b1;
        fault_code_o <= cap_code;
        fault_addr_o <= cap_addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      latency_o       <= '0;
      latency_valid_o <= 1'b0;
    end else if (clear_i) begin
      latency_valid_o <= 1'b0;
    end else begin
      latency_valid_o <= retire;
      if (retire) begin
        latency_o <= cnt_q[hit_idx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int i = 0; i < NumTxns; i++) begin
        id_q[i]    <= '0;
        addr_q[i]  <= '0;
        len_q[i]   <= '0;
        beats_q[i] <= '0;
        cnt_q[i]   <= '0;
        ph_q[i]    <= PhFirst;
        ord_q[i]   <= '0;
      end
    end else if (clear_i) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NumTxns; i++) begin
        if (busy_q[i] && guard_ena_i
            && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end
        if (r_trk && hit && hit_idx == IdxW'(i)) begin
          beats_q[i] <= beats_q[i] + LenWidth'(1);
          ph_q[i]    <= PhLast;
          if (retire) begin
            busy_q[i] <= 1'b0;
          end
        end
        if (retire && busy_q[i]
            && hit_idx != IdxW'(i)
            && id_q[i] == r_id_i
            && ord_q[i] != '0) begin
          ord_q[i] <= ord_q[i] - OutW'(1);
        end
        if (ar_hs && free_idx == IdxW'(i)) begin
          busy_q[i]  <= 1'b1;
          id_q[i]    <= ar_id_i;
          addr_q[i]  <= ar_addr_i;
          len_q[i]   <= ar_len_i;
          beats_q[i] <= '0;
          cnt_q[i]   <= '0;
          ph_q[i]    <= PhFirst;
          ord_q[i]   <= ord_new;
        end
      end
    end
  end

endmodule
